// File: rtl/bcd_score_counter.sv
// bcd_score_counter
//   Decimal (packed BCD) score counter for the game score display.
//   A rising edge on the asynchronous points_clk line is synchronised into
//   clk and adds add_val (clamped to 9) to a DIGITS-wide BCD score.
//   A high-score register, a sticky overflow flag, a sticky new_high flag
//   and a leading-zero blanking mask are maintained alongside.
//
// Parameters
//   DIGITS   : number of BCD digits in score and hiscore (1..16)
//   SATURATE : 0 = wrap modulo 10^DIGITS, 1 = hold at all nines
//
// Ports
//   clk         : system clock, rising edge
//   reset       : synchronous active-low reset
//   points_clk  : asynchronous scoring event line (rising edge = one event)
//   add_val     : BCD amount per event, 10..15 treated as 9
//   stop        : 1 = events dropped, score frozen
//   clear       : clears score, overflow, new_high (hiscore kept)
//   hiscore_clr : clears hiscore only
//   score       : packed BCD score, digit i at [4i+3:4i]
//   hiscore     : packed BCD high score
//   blank       : 1 = digit i is a leading zero (bit 0 always 0)
//   overflow    : sticky, set on carry out of the top digit
//   new_high    : sticky, set whenever hiscore is raised
module bcd_score_counter #(
  parameter int unsigned DIGITS   = 8,
  parameter bit          SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  points_clk,
  input  logic [3:0]            add_val,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  hiscore_clr,
  output logic [4*DIGITS-1:0]   score,
  output logic [4*DIGITS-1:0]   hiscore,
  output logic [DIGITS-1:0]     blank,
  output logic                  overflow,
  output logic                  new_high
);

  localparam int unsigned W = 4 * DIGITS;

  logic         s1_q, s2_q, s3_q;
  logic         s1_d, s2_d, s3_d;
  logic [W-1:0] score_q, score_d;
  logic [W-1:0] hiscore_q, hiscore_d;
  logic         overflow_q, overflow_d;
  logic         new_high_q, new_high_d;

  logic         event_pulse;
  logic [3:0]   add_clamped;
  logic [W-1:0] sum;
  logic         carry;
  logic         carry_out;
  logic [4:0]   digit_sum;
  logic         zero_above;

  // Synchroniser flops reset to 1 so a line held high across reset
  // release must first be seen low before it can produce an event.
  always_comb begin
    s1_d = points_clk;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  assign event_pulse = s2_q & ~s3_q;

  // Ripple decimal add: add_val enters at digit 0, carry walks all digits.
  always_comb begin
    add_clamped = (add_val > 4'd9) ? 4'd9 : add_val;
    sum         = '0;
    carry       = 1'b0;
    digit_sum   = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      digit_sum = {1'b0, score_q[4*i +: 4]}
                + {1'b0, ((i == 0) ? add_clamped : 4'd0)}
                + {4'd0, carry};
      if (digit_sum > 5'd9) begin
        sum[4*i +: 4] = 4'(digit_sum - 5'd10);
        carry         = 1'b1;
      end else begin
        sum[4*i +: 4] = digit_sum[3:0];
        carry         = 1'b0;
      end
    end
    carry_out = carry;
  end

  // Score path: clear > stop > event.  High-score path compares the
  // registered score, so hiscore follows one edge after score changes.
  always_comb begin
    score_d    = score_q;
    overflow_d = overflow_q;
    hiscore_d  = hiscore_q;
    new_high_d = new_high_q;

    if (clear) begin
      score_d    = '0;
      overflow_d = 1'b0;
    end else if (!stop && event_pulse) begin
      if (carry_out) begin
        overflow_d = 1'b1;
        score_d    = SATURATE ? {DIGITS{4'h9}} : sum;
      end else begin
        score_d    = sum;
      end
    end

    // Packed BCD orders the same as its decimal value.
    if (hiscore_clr) begin
      hiscore_d = '0;
    end else if (score_q > hiscore_q) begin
      hiscore_d  = score_q;
      new_high_d = 1'b1;
    end

    if (clear) begin
      new_high_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q       <= 1'b1;
      s2_q       <= 1'b1;
      s3_q       <= 1'b1;
      score_q    <= '0;
      hiscore_q  <= '0;
      overflow_q <= 1'b0;
      new_high_q <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      score_q    <= score_d;
      hiscore_q  <= hiscore_d;
      overflow_q <= overflow_d;
      new_high_q <= new_high_d;
    end
  end

  // Leading-zero mask, scanned from the top digit downwards.
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (score_q[4*i +: 4] == 4'd0);
      blank[i]   = zero_above;
    end
  end

  assign score    = score_q;
  assign hiscore  = hiscore_q;
  assign overflow = overflow_q;
  assign new_high = new_high_q;

endmodule

// File: tb/tb_bcd_score_counter.sv
// Testbench for bcd_score_counter.  Three instances share all inputs:
// 8-digit wrapping, 4-digit wrapping, 4-digit saturating.  A transaction
// level integer model tracks score, hiscore and flags for each.
module tb_bcd_score_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        points_clk;
  logic [3:0]  add_val;
  logic        stop;
  logic        clear;
  logic        hiscore_clr;

  logic [31:0] sc0, hs0;
  logic [7:0]  bl0;
  logic        ov0, nh0;
  logic [15:0] sc1, hs1, sc2, hs2;
  logic [3:0]  bl1, bl2;
  logic        ov1, nh1, ov2, nh2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bcd_score_counter #(.DIGITS(8), .SATURATE(1'b0)) u_w8 (
    .clk(clk), .reset(reset), .points_clk(points_clk), .add_val(add_val),
    .stop(stop), .clear(clear), .hiscore_clr(hiscore_clr),
    .score(sc0), .hiscore(hs0), .blank(bl0), .overflow(ov0), .new_high(nh0));

  bcd_score_counter #(.DIGITS(4), .SATURATE(1'b0)) u_w4 (
    .clk(clk), .reset(reset), .points_clk(points_clk), .add_val(add_val),
    .stop(stop), .clear(clear), .hiscore_clr(hiscore_clr),
    .score(sc1), .hiscore(hs1), .blank(bl1), .overflow(ov1), .new_high(nh1));

  bcd_score_counter #(.DIGITS(4), .SATURATE(1'b1)) u_s4 (
    .clk(clk), .reset(reset), .points_clk(points_clk), .add_val(add_val),
    .stop(stop), .clear(clear), .hiscore_clr(hiscore_clr),
    .score(sc2), .hiscore(hs2), .blank(bl2), .overflow(ov2), .new_high(nh2));

  // ---------------- reference model ----------------
  longint unsigned m_score[3];
  longint unsigned m_hi[3];
  bit              m_ov[3];
  bit              m_nh[3];

  function automatic int unsigned ndig(input int k);
    return (k == 0) ? 8 : 4;
  endfunction

  function automatic longint unsigned lim(input int k);
    return (k == 0) ? 64'd100000000 : 64'd10000;
  endfunction

  function automatic logic [31:0] to_bcd(input longint unsigned v);
    logic [31:0] r;
    longint unsigned t;
    r = '0;
    t = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] exp_blank(input int k);
    logic [7:0] b;
    longint unsigned p;
    b = '0;
    p = 10;
    for (int i = 1; i < int'(ndig(k)); i++) begin
      b[i] = (m_score[k] < p);
      p = p * 10;
    end
    return b;
  endfunction

  function automatic logic [73:0] exp_vec(input int k);
    return {to_bcd(m_score[k]), to_bcd(m_hi[k]), exp_blank(k), m_ov[k], m_nh[k]};
  endfunction

  function automatic logic [73:0] obs(input int k);
    case (k)
      0:       return {sc0, hs0, bl0, ov0, nh0};
      1:       return {16'h0, sc1, 16'h0, hs1, 4'h0, bl1, ov1, nh1};
      default: return {16'h0, sc2, 16'h0, hs2, 4'h0, bl2, ov2, nh2};
    endcase
  endfunction

  task automatic m_settle();
    for (int k = 0; k < 3; k++) begin
      if (m_score[k] > m_hi[k]) begin
        m_hi[k] = m_score[k];
        m_nh[k] = 1'b1;
      end
    end
  endtask

  task automatic m_add(input int a);
    int v;
    longint unsigned s;
    v = (a > 9) ? 9 : a;
    for (int k = 0; k < 3; k++) begin
      s = m_score[k] + longint'(v);
      if (s >= lim(k)) begin
        m_ov[k] = 1'b1;
        m_score[k] = (k == 2) ? lim(k) - 1 : s - lim(k);
      end else begin
        m_score[k] = s;
      end
    end
  endtask

  task automatic m_clear();
    for (int k = 0; k < 3; k++) begin
      m_score[k] = 0;
      m_ov[k] = 1'b0;
      m_nh[k] = 1'b0;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic pulse(input logic [3:0] a, input int hi_cyc, input bit stp);
    @(negedge clk);
    add_val = a;
    stop = stp;
    points_clk = 1'b1;
    repeat (hi_cyc) @(negedge clk);
    points_clk = 1'b0;
    repeat (3) @(negedge clk);
    stop = 1'b0;
    if (!stp) begin
      m_add(int'(a));
      m_settle();
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    m_clear();
    m_settle();
  endtask

  task automatic do_hclr();
    @(negedge clk);
    hiscore_clr = 1'b1;
    @(negedge clk);
    hiscore_clr = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) m_hi[k] = 0;
    m_settle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    points_clk = 1'b1;
    add_val = 4'd1;
    stop = 1'b0;
    clear = 1'b0;
    hiscore_clr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_score[k] = 0; m_hi[k] = 0; m_ov[k] = 1'b0; m_nh[k] = 1'b0;
    end
    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (obs(k) !== exp_vec(k)) begin
        n_err++;
        $display("FAIL reset inst%0d: got %h want %h", k, obs(k), exp_vec(k));
      end
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (obs(k) !== exp_vec(k)) begin
        n_err++;
        $display("FAIL held_high_release inst%0d: got %h want %h", k, obs(k), exp_vec(k));
      end
    end
    @(negedge clk);
    points_clk = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (obs(k) !== exp_vec(k)) begin
        n_err++;
        $display("FAIL first_low inst%0d: got %h want %h", k, obs(k), exp_vec(k));
      end
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    add_val = 4'd1;
    points_clk = 1'b1;
    for (int e = 0; e < 4; e++) begin
      @(posedge clk);
      #1;
      if (e == 2) m_add(1);
      if (e == 3) m_settle();
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (obs(k) !== exp_vec(k)) begin
          n_err++;
          $display("FAIL latency_E%0d inst%0d: got %h want %h", e, k, obs(k), exp_vec(k));
        end
      end
    end
    @(negedge clk);
    points_clk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_clamp();
    do_clear();
    pulse(4'hC, 20, 1'b0);
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (obs(k) !== exp_vec(k)) begin
        n_err++;
        $display("FAIL clamp_hold inst%0d: got %h want %h", k, obs(k), exp_vec(k));
      end
    end
  endtask

  task automatic test_stop();
    for (int p = 0; p < 3; p++) begin
      pulse(4'(1 + p * 3), 1 + p, 1'b1);
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (obs(k) !== exp_vec(k)) begin
          n_err++;
          $display("FAIL stop_pulse%0d inst%0d: got %h want %h", p, k, obs(k), exp_vec(k));
        end
      end
    end
    repeat (4) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (obs(k) !== exp_vec(k)) begin
        n_err++;
        $display("FAIL stop_release inst%0d: got %h want %h", k, obs(k), exp_vec(k));
      end
    end
  endtask

  task automatic test_clear_event();
    @(negedge clk);
    add_val = 4'd7;
    points_clk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    m_clear();
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (obs(k) !== exp_vec(k)) begin
        n_err++;
        $display("FAIL clear_vs_event inst%0d: got %h want %h", k, obs(k), exp_vec(k));
      end
    end
    @(negedge clk);
    clear = 1'b0;
    points_clk = 1'b0;
    repeat (3) @(negedge clk);
    m_settle();
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (obs(k) !== exp_vec(k)) begin
        n_err++;
        $display("FAIL clear_event_lost inst%0d: got %h want %h", k, obs(k), exp_vec(k));
      end
    end
  endtask

  task automatic test_hiscore();
    do_clear();
    do_hclr();
    for (int i = 0; i < 4; i++) pulse(4'd9, 1, 1'b0);
    pulse(4'd4, 1, 1'b0);
    do_clear();
    for (int i = 0; i < 4; i++) pulse(4'd9, 1, 1'b0);
    pulse(4'd4, 1, 1'b0);
    // score 40, hiscore 40, new_high 0; now add 2 and watch hiscore trail.
    @(negedge clk);
    add_val = 4'd2;
    points_clk = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    m_add(2);
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (obs(k) !== exp_vec(k)) begin
        n_err++;
        $display("FAIL hi_before inst%0d: got %h want %h", k, obs(k), exp_vec(k));
      end
    end
    @(posedge clk);
    #1;
    m_settle();
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (obs(k) !== exp_vec(k)) begin
        n_err++;
        $display("FAIL hi_raise inst%0d: got %h want %h", k, obs(k), exp_vec(k));
      end
    end
    @(negedge clk);
    points_clk = 1'b0;
    repeat (3) @(negedge clk);

    // Same again but hiscore_clr collides with the raise.
    do_clear();
    for (int i = 0; i < 4; i++) pulse(4'd9, 1, 1'b0);
    pulse(4'd6, 1, 1'b0);
    @(negedge clk);
    add_val = 4'd3;
    points_clk = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    m_add(3);
    @(negedge clk);
    hiscore_clr = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) m_hi[k] = 0;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (obs(k) !== exp_vec(k)) begin
        n_err++;
        $display("FAIL hclr_collide inst%0d: got %h want %h", k, obs(k), exp_vec(k));
      end
    end
    @(negedge clk);
    hiscore_clr = 1'b0;
    @(posedge clk);
    #1;
    m_settle();
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (obs(k) !== exp_vec(k)) begin
        n_err++;
        $display("FAIL hclr_reload inst%0d: got %h want %h", k, obs(k), exp_vec(k));
      end
    end
    @(negedge clk);
    points_clk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_overflow();
    do_clear();
    for (int i = 0; i < 1110; i++) pulse(4'd9, 1, 1'b0);
    pulse(4'd5, 1, 1'b0);
    pulse(4'd3, 1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (obs(k) !== exp_vec(k)) begin
        n_err++;
        $display("FAIL at_9998 inst%0d: got %h want %h", k, obs(k), exp_vec(k));
      end
    end
    pulse(4'd5, 1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (obs(k) !== exp_vec(k)) begin
        n_err++;
        $display("FAIL wrap_sat inst%0d: got %h want %h", k, obs(k), exp_vec(k));
      end
    end
    pulse(4'd0, 2, 1'b0);
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (obs(k) !== exp_vec(k)) begin
        n_err++;
        $display("FAIL add_zero inst%0d: got %h want %h", k, obs(k), exp_vec(k));
      end
    end
    pulse(4'd7, 1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (obs(k) !== exp_vec(k)) begin
        n_err++;
        $display("FAIL after_overflow inst%0d: got %h want %h", k, obs(k), exp_vec(k));
      end
    end
    do_clear();
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (obs(k) !== exp_vec(k)) begin
        n_err++;
        $display("FAIL clear_keeps_hi inst%0d: got %h want %h", k, obs(k), exp_vec(k));
      end
    end
  endtask

  task automatic test_random();
    int sel;
    for (int t = 0; t < 300; t++) begin
      sel = int'($urandom_range(0, 19));
      if (sel < 14) begin
        pulse(4'($urandom_range(0, 15)), int'($urandom_range(1, 4)), (sel == 0));
      end else if (sel < 16) begin
        do_clear();
      end else if (sel < 18) begin
        do_hclr();
      end else begin
        repeat (2) @(negedge clk);
      end
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (obs(k) !== exp_vec(k)) begin
          n_err++;
          $display("FAIL random_%0d inst%0d: got %h want %h", t, k, obs(k), exp_vec(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_clamp();
    test_stop();
    test_clear_event();
    test_hiscore();
    test_overflow();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
